// File: rtl/alarm_chime_unit.sv
// Hourly strike generator plus N-channel alarm with snooze/stop, timed from an
// internal 8 Hz prescaler off the system clock.
module alarm_chime_unit #(
  parameter int CLK_DIV    = 12_500_000,
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter bit H12        = 1'b0
) (
  input  logic                   CP,
  input  logic                   nCR,
  input  logic [4:0]             HDATA,
  input  logic [7:0]             MDATA,
  input  logic [5*N_ALARM-1:0]   HSET,
  input  logic [6*N_ALARM-1:0]   MSET,
  input  logic [N_ALARM-1:0]     AEN,
  input  logic                   snooze,
  input  logic                   stop,
  output logic                   chime_out,
  output logic                   alarm_out,
  output logic [N_ALARM-1:0]     ringing
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RING_W = $clog2(RING_SEC + 1);
  localparam int SNZ_W = $clog2(SNOOZE_MIN + 1);

  typedef enum logic [1:0] {C_IDLE, C_ON, C_OFF} chime_t;
  typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} alarm_t;

  logic [DIV_W-1:0] div_cnt_reg;
  logic [2:0]       tick_cnt_reg;
  logic             tick8, sec_tick;

  logic [7:0] mdata_reg, mdata_prev_reg;
  logic [4:0] hdata_reg, hour_reg;
  logic [5:0] minute_reg, min_bin;
  logic       min_evt_reg, mdata_valid;

  chime_t     c_state_reg, c_state_next;
  logic [4:0] strikes_reg, strikes_next, strike_load;
  logic [1:0] c_ph_reg, c_ph_next;
  logic       chime_reg, chime_next;

  alarm_t             a_state_reg, a_state_next;
  logic [RING_W-1:0]  ring_cnt_reg, ring_cnt_next;
  logic [SNZ_W-1:0]   snz_cnt_reg, snz_cnt_next;
  logic               alarm_reg, alarm_next;
  logic [N_ALARM-1:0] ringing_reg, ringing_next;
  logic [N_ALARM-1:0] match, match_lowest;
  logic               active_en, ring_timeout;

  // Prescaler: tick8 strobes once per CLK_DIV cycles, sec_tick on every 8th tick8.
  assign tick8    = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign sec_tick = tick8 && (tick_cnt_reg == 3'd7);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      div_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= tick8 ? '0 : div_cnt_reg + DIV_W'(1);
      if (tick8) tick_cnt_reg <= tick_cnt_reg + 3'd1;
    end
  end

  assign mdata_valid = (mdata_reg[3:0] <= 4'd9) && (mdata_reg[7:4] <= 4'd5);
  assign min_bin     = {2'b00, mdata_reg[7:4]} * 6'd10 + {2'b00, mdata_reg[3:0]};

  // Minute/hour are captured together with min_evt so consumers see a consistent time.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      mdata_reg      <= 8'h00;
      mdata_prev_reg <= 8'h00;
      hdata_reg      <= '0;
      hour_reg       <= '0;
      minute_reg     <= '0;
      min_evt_reg    <= 1'b0;
    end else begin
      mdata_reg      <= MDATA;
      mdata_prev_reg <= mdata_reg;
      hdata_reg      <= HDATA;
      hour_reg       <= hdata_reg;
      minute_reg     <= min_bin;
      min_evt_reg    <= (mdata_reg != mdata_prev_reg) && mdata_valid;
    end
  end

  always_comb begin
    if (hour_reg == 5'd0)              strike_load = H12 ? 5'd12 : 5'd24;
    else if (H12 && hour_reg > 5'd12)  strike_load = hour_reg - 5'd12;
    else                               strike_load = hour_reg;
  end

  always_comb begin
    c_state_next = c_state_reg;
    strikes_next = strikes_reg;
    c_ph_next    = c_ph_reg;
    if (min_evt_reg && minute_reg == 6'd0) begin
      c_state_next = C_ON;
      strikes_next = strike_load;
      c_ph_next    = '0;
    end else if (tick8) begin
      case (c_state_reg)
        C_ON: begin
          c_ph_next = c_ph_reg + 2'd1;
          if (c_ph_reg == 2'd3) c_state_next = C_OFF;
        end
        C_OFF: begin
          c_ph_next = c_ph_reg + 2'd1;
          if (c_ph_reg == 2'd3) begin
            strikes_next = strikes_reg - 5'd1;
            c_state_next = (strikes_reg != 5'd1) ? C_ON : C_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_ALARM; gi++) begin : g_match
      assign match[gi] = AEN[gi] && (HSET[5*gi +: 5] == hour_reg) && (MSET[6*gi +: 6] == minute_reg);
    end
  endgenerate

  // Isolate the lowest set bit: lowest-numbered channel wins on simultaneous matches.
  assign match_lowest = match & (~match + N_ALARM'(1));
  assign active_en    = |(AEN & ringing_reg);
  assign ring_timeout = sec_tick && (ring_cnt_reg == RING_W'(RING_SEC - 1));

  always_comb begin
    a_state_next  = a_state_reg;
    ring_cnt_next = ring_cnt_reg;
    snz_cnt_next  = snz_cnt_reg;
    alarm_next    = alarm_reg;
    ringing_next  = ringing_reg;
    case (a_state_reg)
      A_IDLE: begin
        if (min_evt_reg && |match) begin
          a_state_next  = A_RING;
          ringing_next  = match_lowest;
          ring_cnt_next = '0;
          alarm_next    = 1'b1;
        end
      end
      A_RING: begin
        if (stop || !active_en) begin
          a_state_next = A_IDLE;
          ringing_next = '0;
          alarm_next   = 1'b0;
        end else if (snooze) begin
          a_state_next = A_SNOOZE;
          snz_cnt_next = '0;
          alarm_next   = 1'b0;
        end else if (ring_timeout) begin
          a_state_next = A_IDLE;
          ringing_next = '0;
          alarm_next   = 1'b0;
        end else begin
          if (sec_tick) ring_cnt_next = ring_cnt_reg + RING_W'(1);
          if (tick8)    alarm_next    = ~alarm_reg;
        end
      end
      A_SNOOZE: begin
        if (stop || !active_en) begin
          a_state_next = A_IDLE;
          ringing_next = '0;
        end else if (min_evt_reg) begin
          if (snz_cnt_reg == SNZ_W'(SNOOZE_MIN - 1)) begin
            a_state_next  = A_RING;
            ring_cnt_next = '0;
            alarm_next    = 1'b1;
          end else begin
            snz_cnt_next = snz_cnt_reg + SNZ_W'(1);
          end
        end
      end
      default: a_state_next = A_IDLE;
    endcase
  end

  // The strike sequence keeps running while ringing; only its output is masked.
  assign chime_next = (c_state_next == C_ON) && (a_state_next != A_RING);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      c_state_reg  <= C_IDLE;
      strikes_reg  <= '0;
      c_ph_reg     <= '0;
      chime_reg    <= 1'b0;
      a_state_reg  <= A_IDLE;
      ring_cnt_reg <= '0;
      snz_cnt_reg  <= '0;
      alarm_reg    <= 1'b0;
      ringing_reg  <= '0;
    end else begin
      c_state_reg  <= c_state_next;
      strikes_reg  <= strikes_next;
      c_ph_reg     <= c_ph_next;
      chime_reg    <= chime_next;
      a_state_reg  <= a_state_next;
      ring_cnt_reg <= ring_cnt_next;
      snz_cnt_reg  <= snz_cnt_next;
      alarm_reg    <= alarm_next;
      ringing_reg  <= ringing_next;
    end
  end

  assign chime_out = chime_reg;
  assign alarm_out = alarm_reg;
  assign ringing   = ringing_reg;

endmodule
